exe_stage: RTL and testbench

- Execute stage of the 5-stage LoongArch pipeline. Sits directly downstream of the decode stage and upstream of the memory stage.
- Latches the decode-to-execute bus and computes ALU, multiply and iterative-divide results.
- Issues the data-SRAM request for ld.w/st.w.
- Drives the execute forward/block bus back to decode for bypass and load-use/divide interlock.

---
 rtl/exe_stage_pkg.sv | 56 +++++
 rtl/alu.sv | 40 ++++
 rtl/exe_stage_div_unit.sv | 96 +++++++++
 rtl/exe_stage.sv | 132 +++++++++++++
 tb/tb_exe_stage.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/exe_stage_pkg.sv
// Shared widths, ALU opcode bit positions, decode-bus layout and divider states
// for the execute stage and its divider.
// Imported by exe_stage, div_unit and alu.
package exe_stage_pkg;

  localparam int DS_TO_ES_BUS_WD = 156;
  localparam int ES_TO_MS_BUS_WD = 71;
  localparam int ES_FWD_BUS_WD   = 39;

  // One-hot bit positions inside alu_op[11:0]
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  // Field order matches the decode stage's bus concatenation, MSB first
  typedef struct packed {
    logic        mul_signed;
    logic        mul_unsigned;
    logic        mul_high;
    logic        div_signed;
    logic        div_unsigned;
    logic        div_mod;
    logic [11:0] alu_op;
    logic        res_from_mem;
    logic        src1_is_pc;
    logic        src2_is_imm;
    logic        gr_we;
    logic        mem_we;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic [31:0] rj_value;
    logic [31:0] rkd_value;
    logic [31:0] pc;
  } ds_to_es_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_t;

  // Two's-complement negate when neg is set; used for magnitudes and sign fix-up
  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/alu.sv
// Purpose: twelve-operation integer ALU selected by a one-hot opcode.
// Latency: purely combinational.
// Backpressure: none; result follows the operands in the same cycle.
module alu
  import exe_stage_pkg::*;
(
  input  logic [11:0] alu_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  output logic [31:0] alu_result
);

  logic [31:0] sum;
  logic [31:0] diff;
  logic        lt_s;
  logic        lt_u;

  assign sum  = alu_src1 + alu_src2;
  assign diff = alu_src1 - alu_src2;
  assign lt_s = $signed(alu_src1) < $signed(alu_src2);
  assign lt_u = alu_src1 < alu_src2;

  // OR together every enabled result; the opcode is one-hot so at most one contributes
  always_comb begin
    alu_result = 32'd0;
    if (alu_op[ALU_ADD])  alu_result = alu_result | sum;
    if (alu_op[ALU_SUB])  alu_result = alu_result | diff;
    if (alu_op[ALU_SLT])  alu_result = alu_result | {31'd0, lt_s};
    if (alu_op[ALU_SLTU]) alu_result = alu_result | {31'd0, lt_u};
    if (alu_op[ALU_AND])  alu_result = alu_result | (alu_src1 & alu_src2);
    if (alu_op[ALU_NOR])  alu_result = alu_result | ~(alu_src1 | alu_src2);
    if (alu_op[ALU_OR])   alu_result = alu_result | (alu_src1 | alu_src2);
    if (alu_op[ALU_XOR])  alu_result = alu_result | (alu_src1 ^ alu_src2);
    if (alu_op[ALU_SLL])  alu_result = alu_result | (alu_src1 << alu_src2[4:0]);
    if (alu_op[ALU_SRL])  alu_result = alu_result | (alu_src1 >> alu_src2[4:0]);
    if (alu_op[ALU_SRA])  alu_result = alu_result | 32'($signed(alu_src1) >>> alu_src2[4:0]);
    if (alu_op[ALU_LUI])  alu_result = alu_result | alu_src2;
  end

endmodule

// File: rtl/exe_stage_div_unit.sv
// Purpose: 32-bit signed/unsigned radix-2 restoring divider with sign fix-up.
// Latency: done pulses DIV_CYCLES cycles after start (32 iterations + 1 fix cycle).
// Backpressure: none; start is only honoured in IDLE, results hold until the next start.
module div_unit
  import exe_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        div_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam logic [5:0] LAST_ITER = 6'(DIV_CYCLES - 2);

  div_state_t  state;
  div_state_t  state_nxt;
  logic [5:0]  cnt;
  logic [63:0] acc;          // {partial remainder, quotient being shifted in}
  logic [31:0] dvs_mag;
  logic [31:0] dvd_raw;
  logic        q_neg;
  logic        r_neg;
  logic        dvz;
  logic [33:0] trial;
  logic [63:0] acc_nxt;

  // FSM state register; reset aborts any division in flight
  always_ff @(posedge clk) begin
    if (reset) state <= DIV_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      DIV_IDLE: if (start) state_nxt = DIV_BUSY;
      DIV_BUSY: begin
        busy = 1'b1;
        if (cnt == LAST_ITER) state_nxt = DIV_FIX;
      end
      DIV_FIX: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = DIV_IDLE;
      end
      default: state_nxt = DIV_IDLE;
    endcase
  end

  // One restoring step: shift left, try subtracting the divisor from the 33-bit top
  always_comb begin
    trial = {1'b0, acc[63:31]} - {2'b00, dvs_mag};
    if (trial[33]) acc_nxt = {acc[62:0], 1'b0};
    else           acc_nxt = {trial[31:0], acc[30:0], 1'b1};
  end

  // Operand capture on start, iteration in BUSY; registers hold afterwards so results stay valid
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= 6'd0;
      acc     <= 64'd0;
      dvs_mag <= 32'd0;
      dvd_raw <= 32'd0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      dvz     <= 1'b0;
    end else if (state == DIV_IDLE && start) begin
      cnt     <= 6'd0;
      acc     <= {32'd0, neg_if(div_signed & dividend[31], dividend)};
      dvs_mag <= neg_if(div_signed & divisor[31], divisor);
      dvd_raw <= dividend;
      q_neg   <= div_signed & (dividend[31] ^ divisor[31]);
      r_neg   <= div_signed & dividend[31];
      dvz     <= (divisor == 32'd0);
    end else if (state == DIV_BUSY) begin
      cnt <= cnt + 6'd1;
      acc <= acc_nxt;
    end
  end

  // Sign fix-up; divide-by-zero overrides to all-ones quotient and untouched dividend
  assign quotient  = dvz ? 32'hFFFF_FFFF : neg_if(q_neg, acc[31:0]);
  assign remainder = dvz ? dvd_raw       : neg_if(r_neg, acc[63:32]);

endmodule

// File: rtl/exe_stage.sv
// Purpose: pipeline execute stage: ALU, 33x33 multiply, iterative divide, data-SRAM request, bypass bus.
// Latency: one cycle for ALU/multiply/memory ops; divides hold the stage DIV_CYCLES cycles.
// Backpressure: holds the instruction while ms_allowin is low or the divider is running.
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 33
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic [ES_FWD_BUS_WD-1:0]   es_fwd_bus,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_we,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);

  logic        es_valid;
  ds_to_es_t   es_bus;
  logic        es_ready_go;
  logic        es_leave;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] alu_result;
  logic [65:0] mul_prod;
  logic [31:0] mul_result;
  logic        mul_any;
  logic        is_div;
  logic        div_started;
  logic        div_done_r;
  logic        div_start;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic [31:0] div_result;
  logic [31:0] es_result;
  logic        es_fwd_valid;
  logic        es_blk_valid;

  assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid && es_ready_go;
  assign es_leave       = es_valid && es_ready_go && ms_allowin;

  // Stage occupancy
  always_ff @(posedge clk) begin
    if (reset)           es_valid <= 1'b0;
    else if (es_allowin) es_valid <= ds_to_es_valid;
  end

  // Decode bus capture
  always_ff @(posedge clk) begin
    if (reset)                             es_bus <= '0;
    else if (ds_to_es_valid && es_allowin) es_bus <= ds_to_es_bus;
  end

  assign src1 = es_bus.src1_is_pc  ? es_bus.pc  : es_bus.rj_value;
  assign src2 = es_bus.src2_is_imm ? es_bus.imm : es_bus.rkd_value;

  alu u_alu (
    .alu_op     (es_bus.alu_op),
    .alu_src1   (src1),
    .alu_src2   (src2),
    .alu_result (alu_result)
  );

  // Extending to 33 bits lets one signed multiplier serve both signed and unsigned forms
  assign mul_any    = es_bus.mul_signed | es_bus.mul_unsigned;
  assign mul_prod   = $signed({es_bus.mul_signed & src1[31], src1})
                    * $signed({es_bus.mul_signed & src2[31], src2});
  assign mul_result = es_bus.mul_high ? mul_prod[63:32] : mul_prod[31:0];

  assign is_div    = es_bus.div_signed | es_bus.div_unsigned;
  assign div_start = es_valid && is_div && !div_started && !div_busy;

  // done is accepted combinationally so a divide can leave in its done cycle
  assign es_ready_go = !is_div || div_done || div_done_r;

  // Per-instruction divider bookkeeping: prevents restart while a finished result waits on ms_allowin
  always_ff @(posedge clk) begin
    if (reset || es_leave) begin
      div_started <= 1'b0;
      div_done_r  <= 1'b0;
    end else begin
      if (div_start) div_started <= 1'b1;
      if (div_done)  div_done_r  <= 1'b1;
    end
  end

  div_unit #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .start      (div_start),
    .div_signed (es_bus.div_signed),
    .dividend   (src1),
    .divisor    (src2),
    .busy       (div_busy),
    .done       (div_done),
    .quotient   (div_q),
    .remainder  (div_r)
  );

  // div_mod set picks the quotient, clear picks the remainder
  assign div_result = es_bus.div_mod ? div_q : div_r;

  assign es_result = es_bus.res_from_mem ? alu_result :
                     is_div              ? div_result :
                     mul_any             ? mul_result : alu_result;

  assign es_to_ms_bus = {es_bus.res_from_mem, es_bus.gr_we, es_bus.dest, es_result, es_bus.pc};

  // Requests only fire in the transfer cycle, so a stalled store is never issued twice
  assign data_sram_en    = es_valid && (es_bus.res_from_mem || es_bus.mem_we) && ms_allowin;
  assign data_sram_we    = {4{es_valid && es_bus.mem_we && ms_allowin}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = es_bus.rkd_value;

  assign es_fwd_valid = es_valid && es_bus.gr_we && (es_bus.dest != 5'd0)
                        && !es_bus.res_from_mem && es_ready_go;
  assign es_blk_valid = es_valid && es_bus.gr_we && (es_bus.dest != 5'd0)
                        && (es_bus.res_from_mem || !es_ready_go);
  assign es_fwd_bus   = {es_fwd_valid, es_blk_valid, es_bus.dest, es_result};

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: ALU, multiply, divide latency/arithmetic,
// stalled store, divide held by backpressure, and reset during a divide.
module tb_exe_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         ms_allowin;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [155:0] ds_to_es_bus;
  logic         es_to_ms_valid;
  logic [70:0]  es_to_ms_bus;
  logic [38:0]  es_fwd_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  int n_run  = 0;
  int n_fail = 0;
  int we_cnt = 0;

  always #5 clk = ~clk;

  exe_stage #(.DIV_CYCLES(33)) dut (
    .clk             (clk),
    .reset           (reset),
    .ms_allowin      (ms_allowin),
    .es_allowin      (es_allowin),
    .ds_to_es_valid  (ds_to_es_valid),
    .ds_to_es_bus    (ds_to_es_bus),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .es_fwd_bus      (es_fwd_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  // Count full-word store strobes seen mid-cycle
  always @(negedge clk) if (data_sram_we == 4'hF) we_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // md = {mul_signed,mul_unsigned,mul_high,div_signed,div_unsigned,div_mod}
  // ctl = {res_from_mem,src1_is_pc,src2_is_imm,gr_we,mem_we}
  function automatic logic [155:0] mk(input logic [5:0] md, input logic [11:0] op,
                                      input logic [4:0] ctl, input logic [4:0] dest,
                                      input logic [31:0] imm, input logic [31:0] rj,
                                      input logic [31:0] rkd);
    return {md, op, ctl, dest, imm, rj, rkd, 32'h1C00_0100};
  endfunction

  // Present one instruction for one edge (es_allowin is high whenever this is called)
  task automatic send(input logic [155:0] b);
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = b;
    tick();
    ds_to_es_valid = 1'b0;
  endtask

  // Count blocking cycles until the divide completes, then check the result
  task automatic run_div(input string tag, input logic [31:0] exp);
    int n;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (es_fwd_bus[37]) n++;
      else break;
    end
    chk({tag, "_lat"}, n, 32'd33);
    chk({tag, "_vld"}, {31'd0, es_to_ms_valid}, 32'd1);
    chk(tag, es_to_ms_bus[63:32], exp);
  endtask

  localparam logic [11:0] OP_ADD = 12'h001;
  localparam logic [4:0]  C_WR   = 5'b00010;
  localparam logic [4:0]  C_ST   = 5'b00101;

  initial begin
    logic seen_done;
    reset          = 1'b1;
    ms_allowin     = 1'b1;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus   = '0;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_allowin", {31'd0, es_allowin}, 32'd1);
    chk("rst_vld", {31'd0, es_to_ms_valid}, 32'd0);
    chk("rst_fwd", es_fwd_bus[31:0] | {25'd0, es_fwd_bus[38:32]}, 32'd0);
    chk("rst_sram", {27'd0, data_sram_en, data_sram_we}, 32'd0);
    tick();

    // add.w 5 + 7
    send(mk(6'b0, OP_ADD, C_WR, 5'd3, 32'd0, 32'd5, 32'd7));
    @(negedge clk);
    chk("add_vld", {31'd0, es_to_ms_valid}, 32'd1);
    chk("add_res", es_to_ms_bus[63:32], 32'd12);
    chk("add_fwd", {31'd0, es_fwd_bus[38]}, 32'd1);
    chk("add_fwd_dat", es_fwd_bus[31:0], 32'd12);
    tick();

    // div.w -7 / 2 -> -3, mod.w -> -1
    send(mk(6'b000101, 12'd0, C_WR, 5'd4, 32'd0, 32'hFFFF_FFF9, 32'd2));
    run_div("div_w", 32'hFFFF_FFFD);
    tick();
    send(mk(6'b000100, 12'd0, C_WR, 5'd4, 32'd0, 32'hFFFF_FFF9, 32'd2));
    run_div("mod_w", 32'hFFFF_FFFF);
    tick();

    // Multiplies of all-ones operands
    send(mk(6'b011000, 12'd0, C_WR, 5'd5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
    @(negedge clk);
    chk("mulh_wu", es_to_ms_bus[63:32], 32'hFFFF_FFFE);
    tick();
    send(mk(6'b100000, 12'd0, C_WR, 5'd5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
    @(negedge clk);
    chk("mul_w", es_to_ms_bus[63:32], 32'h0000_0001);
    tick();
    send(mk(6'b101000, 12'd0, C_WR, 5'd5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
    @(negedge clk);
    chk("mulh_w", es_to_ms_bus[63:32], 32'h0000_0000);
    tick();

    // st.w stalled three cycles by the memory stage
    ms_allowin = 1'b0;
    we_cnt     = 0;
    send(mk(6'b0, OP_ADD, C_ST, 5'd0, 32'h24, 32'h1000, 32'hDEAD_BEEF));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("st_stall_we", {28'd0, data_sram_we}, 32'd0);
      chk("st_stall_allowin", {31'd0, es_allowin}, 32'd0);
      tick();
    end
    ms_allowin = 1'b1;
    @(negedge clk);
    chk("st_we", {28'd0, data_sram_we}, 32'hF);
    chk("st_en", {31'd0, data_sram_en}, 32'd1);
    chk("st_addr", data_sram_addr, 32'h1024);
    chk("st_wdata", data_sram_wdata, 32'hDEAD_BEEF);
    tick();
    @(negedge clk);
    chk("st_after_we", {28'd0, data_sram_we}, 32'd0);
    chk("st_once", we_cnt, 32'd1);
    tick();

    // Unsigned divide by zero, and the signed overflow case
    send(mk(6'b000011, 12'd0, C_WR, 5'd6, 32'd0, 32'd100, 32'd0));
    run_div("divu_z", 32'hFFFF_FFFF);
    tick();
    send(mk(6'b000010, 12'd0, C_WR, 5'd6, 32'd0, 32'd100, 32'd0));
    run_div("modu_z", 32'd100);
    tick();
    send(mk(6'b000101, 12'd0, C_WR, 5'd6, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF));
    run_div("div_ovf", 32'h8000_0000);
    tick();
    send(mk(6'b000100, 12'd0, C_WR, 5'd6, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF));
    run_div("mod_ovf", 32'd0);
    tick();

    // div.wu 100/7 finishing while the memory stage is stalled: result held, no restart
    ms_allowin = 1'b0;
    send(mk(6'b000011, 12'd0, C_WR, 5'd7, 32'd0, 32'd100, 32'd7));
    run_div("div_hold", 32'd14);
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      chk("hold_res", es_to_ms_bus[63:32], 32'd14);
      chk("hold_idle", {31'd0, dut.u_div.busy}, 32'd0);
    end
    tick();
    ms_allowin = 1'b1;
    tick();
    @(negedge clk);
    chk("hold_left", {31'd0, es_to_ms_valid}, 32'd0);
    tick();

    // Reset ten cycles into a divide
    send(mk(6'b000101, 12'd0, C_WR, 5'd8, 32'd0, 32'd1000, 32'd7));
    for (int k = 0; k < 10; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rdiv_vld", {31'd0, es_to_ms_valid}, 32'd0);
    chk("rdiv_allowin", {31'd0, es_allowin}, 32'd1);
    chk("rdiv_idle", {31'd0, dut.u_div.busy}, 32'd0);
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      seen_done = seen_done | dut.u_div.done;
    end
    chk("rdiv_no_done", {31'd0, seen_done}, 32'd0);
    tick();
    send(mk(6'b0, OP_ADD, C_WR, 5'd9, 32'd0, 32'd20, 32'd22));
    @(negedge clk);
    chk("radd_vld", {31'd0, es_to_ms_valid}, 32'd1);
    chk("radd_res", es_to_ms_bus[63:32], 32'd42);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
